// File: rtl/board_writer_pkg.sv
// Shared definitions for the 4x4 board writer: cell and bus widths, FSM state
// encoding, move direction codes, default parameters and board helpers.
package board_writer_pkg;

  localparam int unsigned CELL_W    = 4;
  localparam int unsigned NUM_CELLS = 16;
  localparam int unsigned ADDR_W    = 11;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned LFSR_W    = 16;

  localparam logic [ADDR_W-1:0] BASE_ADDR_DEF = 11'd256;
  localparam int unsigned       MAX_EXP_DEF   = 11;
  localparam logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MOVE   = 3'd1;
  localparam logic [2:0] ST_SPAWN  = 3'd2;
  localparam logic [2:0] ST_WRITE  = 3'd3;
  localparam logic [2:0] ST_FINISH = 3'd4;

  // Move direction codes
  localparam logic [1:0] DIR_LEFT  = 2'd0;
  localparam logic [1:0] DIR_RIGHT = 2'd1;
  localparam logic [1:0] DIR_UP    = 2'd2;
  localparam logic [1:0] DIR_DOWN  = 2'd3;

  typedef logic [CELL_W-1:0] exp_t;
  typedef exp_t [3:0]        line_t;
  typedef exp_t [NUM_CELLS-1:0] board_t;

  // Cell index of position j (0 = leading end) in line k for a direction.
  // Cell i sits at row i[3:2], column i[1:0].
  function automatic logic [3:0] line_cell(input logic [1:0] dir,
                                           input logic [1:0] k,
                                           input logic [1:0] j);
    logic [3:0] idx;
    case (dir)
      DIR_LEFT:  idx = {k, j};
      DIR_RIGHT: idx = {k, ~j};
      DIR_UP:    idx = {j, k};
      default:   idx = {~j, k};
    endcase
    return idx;
  endfunction

  // True when no cell is empty and no two orthogonal neighbours are equal.
  function automatic logic board_stuck(input board_t b);
    logic stuck;
    stuck = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (b[4'(4 * r + c)] == '0) stuck = 1'b0;
        if (c < 3 && b[4'(4 * r + c)] == b[4'(4 * r + c + 1)]) stuck = 1'b0;
        if (r < 3 && b[4'(4 * r + c)] == b[4'(4 * r + c + 4)]) stuck = 1'b0;
      end
    end
    return stuck;
  endfunction

endpackage

// File: rtl/board_writer_if.sv
// Move request / board-RAM write bundle of the board writer.
//   move_valid, move_dir : request strobe and direction (master -> slave)
//   busy                 : request in progress
//   wea, addra, dina     : board-RAM write port
//   done, moved          : completion pulse and "board changed" flag
//   game_over            : sticky no-moves-left indication
interface board_writer_if;
  import board_writer_pkg::*;

  logic              move_valid;
  logic [1:0]        move_dir;
  logic              busy;
  logic              wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;
  logic              done;
  logic              moved;
  logic              game_over;

  modport master (
    output move_valid, move_dir,
    input  busy, wea, addra, dina, done, moved, game_over
  );

  modport slave (
    input  move_valid, move_dir,
    output busy, wea, addra, dina, done, moved, game_over
  );

endinterface

// File: rtl/board_writer_line_merge.sv
// Combinational compact-and-merge of one 4-cell line toward position 0.
//   line_in  : 4 exponents, index 0 is the leading end
//   line_out : compacted line with equal neighbours merged once each
//   changed  : line_out differs from line_in
module line_merge
  import board_writer_pkg::*;
#(
  parameter int unsigned MAX_EXP = MAX_EXP_DEF
) (
  input  line_t line_in,
  output line_t line_out,
  output logic  changed
);

  // One spare zero slot so the look-ahead at the last tile never runs off the end
  exp_t       comp [5];
  logic [2:0] cnt;
  logic [2:0] k;
  logic       skip;

  always_comb begin
    for (int i = 0; i < 5; i++) comp[i] = '0;
    cnt = '0;
    // Squeeze out empty cells
    for (int i = 0; i < 4; i++) begin
      if (line_in[2'(i)] != '0) begin
        comp[cnt] = line_in[2'(i)];
        cnt       = cnt + 3'd1;
      end
    end

    // Merge from the leading end; a merged pair consumes both tiles
    line_out = '0;
    k        = '0;
    skip     = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (comp[3'(i)] != '0) begin
        if (comp[3'(i)] == comp[3'(i + 1)] && comp[3'(i)] != exp_t'(MAX_EXP)) begin
          line_out[k[1:0]] = comp[3'(i)] + exp_t'(1);
          skip             = 1'b1;
        end else begin
          line_out[k[1:0]] = comp[3'(i)];
        end
        k = k + 3'd1;
      end
    end

    changed = (line_out != line_in);
  end

endmodule

// File: rtl/board_writer.sv
// 4x4 sliding-tile board engine. Holds 16 exponent cells, applies a move one
// line per cycle, spawns a new tile at a pseudo-random empty cell, then
// streams the whole board into an external RAM and reports completion.
//   clk, rst : clock and synchronous active-high reset (reset runs an init
//              sequence: two spawns, full board write, done with moved=1)
//   bw       : slave side of board_writer_if (request in, RAM write + status out)
module board_writer
  import board_writer_pkg::*;
#(
  parameter logic [ADDR_W-1:0] BASE_ADDR = BASE_ADDR_DEF,
  parameter int unsigned       MAX_EXP   = MAX_EXP_DEF
) (
  input  logic          clk,
  input  logic          rst,
  board_writer_if.slave bw
);

  logic [2:0]        state;
  logic [2:0]        state_d;
  board_t            cells;
  board_t            cells_d;
  logic [1:0]        dir;
  logic [1:0]        line_k;
  logic              changed_any;
  logic              changed_now;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_fb;
  logic [3:0]        scan_idx;
  logic [3:0]        scan_cnt;
  logic [1:0]        spawn_left;
  logic              spawn_hit;
  logic              scan_end;
  exp_t              spawn_val;
  logic [3:0]        wr_idx;
  logic [3:0]        wr_idx_d;
  line_t             line_in;
  line_t             line_out;
  logic              line_changed;

  logic              busy_q;
  logic              wea_q;
  logic [ADDR_W-1:0] addra_q;
  logic [DATA_W-1:0] dina_q;
  logic              done_q;
  logic              moved_q;
  logic              game_over_q;

  // Gather the line under work in leading-end-first order
  always_comb begin
    for (int j = 0; j < 4; j++) begin
      line_in[2'(j)] = cells[line_cell(dir, line_k, 2'(j))];
    end
  end

  line_merge #(.MAX_EXP(MAX_EXP)) u_line_merge (
    .line_in  (line_in),
    .line_out (line_out),
    .changed  (line_changed)
  );

  // Once the game is over the board is frozen, so moves never report a change
  assign changed_now = changed_any | (line_changed & ~game_over_q);
  assign spawn_hit   = (cells[scan_idx] == '0);
  assign scan_end    = spawn_hit | (scan_cnt == 4'd15);
  assign spawn_val   = (lfsr[7:4] == 4'd0) ? exp_t'(2) : exp_t'(1);
  assign lfsr_fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  assign wr_idx_d    = (state == ST_WRITE) ? wr_idx + 4'd1 : 4'd0;

  // Next-state logic
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (bw.move_valid) state_d = ST_MOVE;
      ST_MOVE:   if (line_k == 2'd3) state_d = changed_now ? ST_SPAWN : ST_FINISH;
      ST_SPAWN:  if (scan_end && spawn_left == 2'd1) state_d = ST_WRITE;
      ST_WRITE:  if (wr_idx == 4'd15) state_d = ST_FINISH;
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next board contents: merged line during MOVE, new tile during SPAWN
  always_comb begin
    cells_d = cells;
    if (state == ST_MOVE && !game_over_q) begin
      for (int j = 0; j < 4; j++) begin
        cells_d[line_cell(dir, line_k, 2'(j))] = line_out[2'(j)];
      end
    end else if (state == ST_SPAWN && spawn_hit) begin
      cells_d[scan_idx] = spawn_val;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_SPAWN;
    else     state <= state_d;
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cells       <= '0;
      lfsr        <= LFSR_SEED;
      dir         <= DIR_LEFT;
      line_k      <= '0;
      changed_any <= 1'b1;
      scan_idx    <= LFSR_SEED[3:0];
      scan_cnt    <= '0;
      spawn_left  <= 2'd2;
      wr_idx      <= '0;
      busy_q      <= 1'b1;
      wea_q       <= 1'b0;
      addra_q     <= '0;
      dina_q      <= '0;
      done_q      <= 1'b0;
      moved_q     <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      cells <= cells_d;
      lfsr  <= {lfsr[14:0], lfsr_fb};

      case (state)
        ST_IDLE: begin
          if (bw.move_valid) begin
            dir         <= bw.move_dir;
            line_k      <= '0;
            changed_any <= 1'b0;
          end
        end
        ST_MOVE: begin
          line_k      <= line_k + 2'd1;
          changed_any <= changed_now;
          // The value loaded on the last MOVE cycle seeds the spawn scan
          scan_idx    <= lfsr[3:0];
          scan_cnt    <= '0;
          spawn_left  <= 2'd1;
        end
        ST_SPAWN: begin
          if (scan_end) begin
            // Reseed for a possible second spawn of the init sequence
            spawn_left <= spawn_left - 2'd1;
            scan_idx   <= lfsr[3:0];
            scan_cnt   <= '0;
          end else begin
            scan_idx <= scan_idx + 4'd1;
            scan_cnt <= scan_cnt + 4'd1;
          end
        end
        default: ;
      endcase

      // Write port driven from the next state so wea lines up with WRITE
      wr_idx  <= (state_d == ST_WRITE) ? wr_idx_d : 4'd0;
      busy_q  <= (state_d != ST_IDLE);
      wea_q   <= (state_d == ST_WRITE);
      addra_q <= (state_d == ST_WRITE) ? BASE_ADDR + ADDR_W'(wr_idx_d) : '0;
      dina_q  <= (state_d == ST_WRITE) ? DATA_W'(cells_d[wr_idx_d]) : '0;

      done_q  <= (state == ST_FINISH);
      moved_q <= (state == ST_FINISH) & changed_any;
      if (state == ST_FINISH && board_stuck(cells)) game_over_q <= 1'b1;
    end
  end

  assign bw.busy      = busy_q;
  assign bw.wea       = wea_q;
  assign bw.addra     = addra_q;
  assign bw.dina      = dina_q;
  assign bw.done      = done_q;
  assign bw.moved     = moved_q;
  assign bw.game_over = game_over_q;

endmodule

// File: tb/tb_board_writer.sv
// Scoreboard bench for board_writer: stimulus pushes the expected completion
// (moved, game_over, write count, written board, latency window) and a
// negedge monitor checks each done against the head of the queue.
module tb_board_writer;
  import board_writer_pkg::*;

  typedef struct {
    string  name;
    logic   moved;
    logic   go;
    int     n_wr;
    int     n_sp;
    board_t board;
    int     acc;
    int     lat_min;
    int     lat_max;
  } tb_exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;
  logic [31:0] wr_data [16];
  tb_exp_t     exp_q [$];
  board_t      force_val;

  board_writer_if bw ();

  board_writer #(.BASE_ADDR(11'd256), .MAX_EXP(11)) dut (
    .clk (clk),
    .rst (rst),
    .bw  (bw)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Monitor: capture RAM writes, score every done against the queue head
  always @(negedge clk) begin
    tb_exp_t     e;
    int          bad;
    int          sp;
    logic [31:0] want;
    if (rst) begin
      wr_cnt = 0;
    end else begin
      if (bw.wea) begin
        chk("wr_addr", int'(bw.addra), 256 + wr_cnt);
        if (wr_cnt < 16) wr_data[wr_cnt] = bw.dina;
        wr_cnt++;
      end
      if (bw.done) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk({e.name, "_moved"}, int'(bw.moved), int'(e.moved));
          chk({e.name, "_game_over"}, int'(bw.game_over), int'(e.go));
          chk({e.name, "_writes"}, wr_cnt, e.n_wr);
          chk_rng({e.name, "_latency"}, cyc - e.acc, e.lat_min, e.lat_max);
          if (e.n_wr == 16 && wr_cnt == 16) begin
            bad = 0;
            sp  = 0;
            for (int i = 0; i < 16; i++) begin
              want = {28'b0, e.board[i]};
              if (wr_data[i] === want) ;
              else if (e.board[i] == '0 && (wr_data[i] == 32'd1 || wr_data[i] == 32'd2)) sp++;
              else bad++;
            end
            chk({e.name, "_board_cells"}, bad, 0);
            chk({e.name, "_spawned"}, sp, e.n_sp);
          end
        end
        wr_cnt = 0;
      end
    end
  end

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    chk({name, "_done_seen"}, int'(done_cnt >= target), 1);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && bw.busy; i++) @(negedge clk);
    chk({name, "_idle"}, int'(bw.busy), 0);
  endtask

  task automatic push_init(input string name);
    tb_exp_t e;
    e.name = name; e.moved = 1'b1; e.go = 1'b0; e.n_wr = 16; e.n_sp = 2;
    e.board = '0; e.acc = cyc; e.lat_min = 0; e.lat_max = 1000;
    exp_q.push_back(e);
  endtask

  // Load a board, issue one move, optionally poke move_valid during WRITE
  task automatic run_move(input string name, input board_t bin, input logic [1:0] d,
                          input board_t bout, input logic mv, input logic go,
                          input bit pulse);
    tb_exp_t e;
    int      target;
    wait_idle(name);
    force_val = bin;
    force dut.cells = force_val;
    @(negedge clk);
    release dut.cells;
    e.name = name; e.moved = mv; e.go = go;
    e.n_wr = mv ? 16 : 0; e.n_sp = mv ? 1 : 0; e.board = bout;
    e.acc = cyc; e.lat_min = mv ? 23 : 6; e.lat_max = mv ? 38 : 6;
    exp_q.push_back(e);
    target = done_cnt + 1;
    bw.move_dir   = d;
    bw.move_valid = 1'b1;
    @(negedge clk);
    bw.move_valid = 1'b0;
    if (pulse) begin
      for (int i = 0; i < 60 && !bw.wea; i++) @(negedge clk);
      chk({name, "_wea_seen"}, int'(bw.wea), 1);
      bw.move_dir   = DIR_RIGHT;
      bw.move_valid = 1'b1;
      @(negedge clk);
      bw.move_valid = 1'b0;
    end
    wait_done(target, 80, name);
  endtask

  initial begin
    board_t bi;
    board_t bo;
    int     d0;
    bw.move_valid = 1'b0;
    bw.move_dir   = DIR_LEFT;

    // Reset values and the init sequence
    push_init("init");
    @(negedge clk);
    chk("rst_busy", int'(bw.busy), 1);
    chk("rst_wea", int'(bw.wea), 0);
    chk("rst_done", int'(bw.done), 0);
    chk("rst_moved", int'(bw.moved), 0);
    chk("rst_game_over", int'(bw.game_over), 0);
    rst = 1'b0;
    wait_done(1, 100, "init");

    // [1,1,1,1] left -> [2,2,0,0]
    bi = '0; bi[0] = 4'd1; bi[1] = 4'd1; bi[2] = 4'd1; bi[3] = 4'd1;
    bo = '0; bo[0] = 4'd2; bo[1] = 4'd2;
    run_move("merge_left", bi, DIR_LEFT, bo, 1'b1, 1'b0, 1'b0);

    // Nothing can slide
    bi = '0; bi[0] = 4'd2;
    run_move("noop_left", bi, DIR_LEFT, bi, 1'b0, 1'b0, 1'b0);

    // Top tiles never merge
    bi = '0; bi[0] = 4'd11; bi[4] = 4'd11;
    run_move("cap_up", bi, DIR_UP, bi, 1'b0, 1'b0, 1'b0);

    // Row 1 [2,2,2,0] right -> [0,0,2,3]; row 3 stays
    bi = '0; bi[4] = 4'd2; bi[5] = 4'd2; bi[6] = 4'd2;
    bi[12] = 4'd1; bi[13] = 4'd2; bi[14] = 4'd1; bi[15] = 4'd2;
    bo = bi; bo[4] = 4'd0; bo[5] = 4'd0; bo[6] = 4'd2; bo[7] = 4'd3;
    run_move("slide_right", bi, DIR_RIGHT, bo, 1'b1, 1'b0, 1'b0);

    // Column 1 top-down [1,0,1,3] down -> [0,0,2,3]; column 0 tile drops
    bi = '0; bi[0] = 4'd5; bi[1] = 4'd1; bi[9] = 4'd1; bi[13] = 4'd3;
    bo = '0; bo[12] = 4'd5; bo[13] = 4'd3; bo[9] = 4'd2;
    run_move("slide_down", bi, DIR_DOWN, bo, 1'b1, 1'b0, 1'b0);

    // Column 2 [2,2,4,4] up -> [3,5,0,0]
    bi = '0; bi[2] = 4'd2; bi[6] = 4'd2; bi[10] = 4'd4; bi[14] = 4'd4;
    bo = '0; bo[2] = 4'd3; bo[6] = 4'd5;
    run_move("pairs_up", bi, DIR_UP, bo, 1'b1, 1'b0, 1'b0);

    // Request during WRITE is dropped
    bi = '0; bi[8] = 4'd3; bi[9] = 4'd3;
    bo = '0; bo[8] = 4'd4;
    run_move("busy_ignore", bi, DIR_LEFT, bo, 1'b1, 1'b0, 1'b1);
    d0 = done_cnt;
    repeat (50) @(negedge clk);
    chk("busy_ignore_single_done", done_cnt, d0);

    // Checkerboard of 1/2: no move possible, game over is sticky
    bi = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        bi[4 * r + c] = ((r + c) % 2 == 1) ? 4'd2 : 4'd1;
    run_move("gameover_left", bi, DIR_LEFT, bi, 1'b0, 1'b1, 1'b0);
    run_move("gameover_up", bi, DIR_UP, bi, 1'b0, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    chk("gameover_held", int'(bw.game_over), 1);

    // Reset clears game over and reruns init
    push_init("reinit");
    rst = 1'b1;
    @(negedge clk);
    chk("rerst_game_over", int'(bw.game_over), 0);
    chk("rerst_busy", int'(bw.busy), 1);
    rst = 1'b0;
    d0 = done_cnt;
    wait_done(d0 + 1, 100, "reinit");

    repeat (5) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/board_writer.md
BOARD_WRITER -- requirements
Module: board_writer

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 11'd256, giving the board-RAM address of cell 0.
REQ-002 The module SHALL have parameter MAX_EXP, default 11, giving the exponent of the highest tile (2048).
REQ-003 The module SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; every register SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 move_valid  input  1  move request strobe.
REQ-007 move_dir  input  2  move direction: 0=left, 1=right, 2=up, 3=down.
REQ-008 busy  output  1  high while a request is being processed.
REQ-009 wea  output  1  board-RAM write enable.
REQ-010 addra  output  11  board-RAM write address.
REQ-011 dina  output  32  board-RAM write data: {28'b0, exponent}.
REQ-012 done  output  1  one-cycle pulse when a request, or the reset init sequence, completes.
REQ-013 moved  output  1  valid with done: 1 if the board changed.
REQ-014 game_over  output  1  sticky until rst: no empty cell and no equal orthogonal neighbours.

Function
REQ-015 The module SHALL hold the board as 16 registered 4-bit exponents: cell i = row i/4, column i%4; 0 = empty; n = tile 2^n.
REQ-016 The module SHALL implement FSM states IDLE, MOVE, SPAWN, WRITE, FINISH.
REQ-017 In IDLE with busy=0, a request with move_valid=1 SHALL be accepted and the direction latched.
  - move_valid while busy=1 SHALL be ignored, not queued.
  - After acceptance, busy SHALL be 1 from the next cycle until FINISH.
REQ-018 MOVE SHALL take exactly 4 cycles and process line k in cycle k.
  - Left: cells 4k..4k+3.
  - Right: cells 4k+3..4k.
  - Up: cells k, k+4, k+8, k+12.
  - Down: cells k+12, k+8, k+4, k.
  - Each line SHALL be compacted toward the first position.
REQ-019 Merge rules within a line:
  - Two equal adjacent non-zero tiles SHALL merge into one tile of exponent+1.
  - Merging SHALL work from the leading end.
  - A tile SHALL merge at most once per move.
  - Tiles equal to MAX_EXP SHALL NOT merge.
REQ-020 If no cell changed after MOVE, the FSM SHALL skip SPAWN and WRITE, go to FINISH, and report moved=0.
REQ-021 SPAWN start and scan:
  - The start index SHALL be lfsr[3:0].
  - The scan SHALL test one cell per cycle, incrementing the index mod 16, for at most 16 cycles.
REQ-022 The first empty cell found SHALL be set to exponent 1, or to 2 when lfsr[7:4]==0.
  - If no cell is empty, no cell SHALL be placed.
REQ-023 lfsr SHALL be a 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running every cycle.
REQ-024 WRITE SHALL take exactly 16 cycles.
  - Cycle i: wea=1, addra=BASE_ADDR+i, dina={28'b0,cell[i]}.
  - wea SHALL be 0 in every other state.
REQ-025 FINISH SHALL last 1 cycle and assert done.
  - moved SHALL be 1 if the board changed.
  - game_over SHALL be evaluated and set here.
  - The FSM SHALL then return to IDLE with busy=0.
REQ-026 Latency: a changed move SHALL complete (done) within 1+4+16+16+1 cycles of acceptance; an unchanged move SHALL complete in 6 cycles.
REQ-027 After game_over=1, move requests SHALL still be accepted and SHALL yield moved=0.

Reset
REQ-028 rst SHALL override every state, including mid-WRITE.
REQ-029 On rst, all cells SHALL be 0, lfsr SHALL be 16'hACE1, and wea, done, moved, game_over SHALL be 0.
REQ-030 On rst, busy SHALL be 1 and the FSM SHALL enter SPAWN.
REQ-031 The post-reset init sequence SHALL be: SPAWN twice, WRITE all 16 cells, FINISH with done=1 and moved=1.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the direction codes, BASE_ADDR, MAX_EXP and the cell width (4).
REQ-033 The module SHALL use one combinational sub-module, line_merge: 4 exponents in, 4 compacted/merged exponents out, plus a changed flag.

Verification
REQ-034 Line merge:
  - Row 0 = [1,1,1,1], left -> row 0 = [2,2,0,0], moved=1.
  - 16 writes at 256..271; cell 256 = 2.
REQ-035 No-op move:
  - Row 0 = [2,0,0,0], others empty, left -> done 6 cycles after acceptance, moved=0.
  - No wea pulse.
REQ-036 Cap: column 0 = [11,11,0,0], up -> column 0 unchanged, moved=0.
REQ-037 Init after reset:
  - rst for 1 cycle -> exactly two non-zero cells, each 1 or 2.
  - 16 writes, then done=1.
REQ-038 Busy ignore: move_valid pulsed during WRITE -> no second done; board reflects the first move only.
REQ-039 Game over: board full as a checkerboard of 1 and 2, any move -> moved=0, game_over=1, held until rst.
